// File: rtl/counter_cmd_seq.sv
// Command sequencer for the up/down counter: queues LOAD/UP/DOWN commands in
// a small FIFO and plays them out as registered load/updown/data phases.
module counter_cmd_seq #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     load,
  output logic                     updown,
  output logic [WIDTH-1:0]         data,
  output logic                     busy,
  output logic                     cmd_done,
  output logic                     cmd_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_RSV  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOADING,
    S_RUN
  } state_t;

  // Command FIFO storage and pointers
  op_t              mem_op   [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [LEN_W-1:0] mem_len  [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, empty, full;

  op_t              head_op;
  logic [WIDTH-1:0] head_data;
  logic [LEN_W-1:0] head_len, head_len1;

  // Sequencer state and registered outputs
  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             load_q, load_d;
  logic             updown_q, updown_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             decode;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign fifo_level = count;

  assign head_op    = mem_op[rd_ptr];
  assign head_data  = mem_data[rd_ptr];
  assign head_len   = mem_len[rd_ptr];
  assign head_len1  = (head_len == '0) ? LEN_W'(1) : head_len;

  assign load     = load_q;
  assign updown   = updown_q;
  assign data     = data_q;
  assign busy     = busy_q;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;

  // FIFO payload write; storage needs no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= op_t'(cmd_op);
      mem_data[wr_ptr] <= cmd_data;
      mem_len[wr_ptr]  <= cmd_len;
    end
  end

  // FIFO pointers and occupancy, push and pop of the same edge combined
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      load_q   <= 1'b0;
      updown_q <= 1'b1;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      load_q   <= load_d;
      updown_q <= updown_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-output logic; every slot that may pop funnels into a
  // shared decode so LOAD/RUN end cycles chain into the next command directly
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    load_d   = 1'b0;
    updown_d = updown_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    decode   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (!empty) decode = 1'b1;
      end
      S_LOADING: begin
        if (!empty) begin
          decode = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (rem_q == LEN_W'(1)) begin
          if (!empty) begin
            decode = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          rem_d  = rem_q - LEN_W'(1);
          // cmd_done is registered, so flag it one cycle before rem reaches 1
          done_d = (rem_q == LEN_W'(2));
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (decode) begin
      case (head_op)
        OP_LOAD: begin
          load_d  = 1'b1;
          data_d  = head_data;
          busy_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_LOADING;
        end
        OP_UP, OP_DOWN: begin
          updown_d = (head_op == OP_UP);
          busy_d   = 1'b1;
          rem_d    = head_len1;
          done_d   = (head_len1 == LEN_W'(1));
          state_d  = S_RUN;
        end
        default: begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign pop = decode;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: a trace-expansion model of the command stream
// checked every cycle, plus directed scenarios with literal expectations and
// a behavioural counter fed by the sequencer outputs.
module tb_counter_cmd_seq;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int DEPTH = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             load;
  logic             updown;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             cmd_done;
  logic             cmd_err;
  logic [$clog2(DEPTH):0] fifo_level;

  counter_cmd_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .load       (load),
    .updown     (updown),
    .data       (data),
    .busy       (busy),
    .cmd_done   (cmd_done),
    .cmd_err    (cmd_err),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream up/down counter driven by the sequencer
  logic [WIDTH-1:0] cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (load)   cnt <= data;
    else if (updown) cnt <= cnt + 8'd1;
    else             cnt <= cnt - 8'd1;
  end

  typedef struct packed {
    logic             load;
    logic             updown;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic             err;
  } out_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] d;
    logic [LEN_W-1:0] len;
  } cmd_t;

  cmd_t mq[$];    // accepted, not yet popped
  out_t pend[$];  // committed future output cycles
  out_t cur;      // outputs expected in the current cycle

  int errors = 0;
  int checks = 0;

  function automatic out_t mk(logic l, logic u, logic [WIDTH-1:0] d,
                              logic b, logic dn, logic e);
    out_t o;
    o.load = l; o.updown = u; o.data = d; o.busy = b; o.done = dn; o.err = e;
    return o;
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    cur = mk(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance the model over one rising edge using the inputs now applied
  task automatic model_step();
    cmd_t c;
    bit   can_push;
    int   n;
    can_push = cmd_valid && (mq.size() < DEPTH);
    if (pend.size() == 0 && mq.size() != 0) begin
      c = mq.pop_front();
      case (c.op)
        OP_LOAD: pend.push_back(mk(1'b1, cur.updown, c.d, 1'b1, 1'b1, 1'b0));
        OP_UP, OP_DOWN: begin
          n = (c.len == 0) ? 1 : int'(c.len);
          for (int i = 0; i < n; i++)
            pend.push_back(mk(1'b0, c.op == OP_UP, cur.data, 1'b1, i == n - 1, 1'b0));
        end
        default: pend.push_back(mk(1'b0, cur.updown, cur.data, 1'b0, 1'b0, 1'b1));
      endcase
    end
    if (can_push) begin
      c.op = cmd_op; c.d = cmd_data; c.len = cmd_len;
      mq.push_back(c);
    end
    if (pend.size() != 0) cur = pend.pop_front();
    else                  cur = mk(1'b0, cur.updown, cur.data, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("load",       32'(load),       32'(cur.load));
    chk("updown",     32'(updown),     32'(cur.updown));
    chk("data",       32'(data),       32'(cur.data));
    chk("busy",       32'(busy),       32'(cur.busy));
    chk("cmd_done",   32'(cmd_done),   32'(cur.done));
    chk("cmd_err",    32'(cmd_err),    32'(cur.err));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("cmd_ready",  32'(cmd_ready),  32'(mq.size() < DEPTH));
  endtask

  // One clock: model the coming edge, then compare at the following negedge
  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] d,
                      input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] ce [4];

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_load",   32'(load),       32'h0);
    chk("rst_updown", 32'(updown),     32'h1);
    chk("rst_data",   32'(data),       32'h0);
    chk("rst_busy",   32'(busy),       32'h0);
    chk("rst_level",  32'(fifo_level), 32'h0);
    chk("rst_ready",  32'(cmd_ready),  32'h1);
    rst = 1'b0;
    tick();

    // LOAD A5 then UP 5
    push(OP_LOAD, 8'hA5, 8'd0);
    push(OP_UP, 8'h00, 8'd5);
    chk("a_load", 32'(load), 32'h1);
    chk("a_data", 32'(data), 32'hA5);
    chk("a_done", 32'(cmd_done), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("a_up",      32'(updown),   32'h1);
      chk("a_up_load", 32'(load),     32'h0);
      chk("a_up_done", 32'(cmd_done), 32'(i == 4));
    end
    tick();
    chk("a_idle_busy", 32'(busy), 32'h0);
    chk("a_cnt",       32'(cnt),  32'hAA);

    // DOWN len 0 is a single cycle
    push(OP_DOWN, 8'h00, 8'd0);
    tick();
    chk("b_updown", 32'(updown),   32'h0);
    chk("b_done",   32'(cmd_done), 32'h1);
    chk("b_busy",   32'(busy),     32'h1);
    tick();
    chk("b_idle_busy",   32'(busy),   32'h0);
    chk("b_idle_updown", 32'(updown), 32'h0);

    // Fill the FIFO behind a long UP phase
    push(OP_UP, 8'h00, 8'd20);
    push(OP_LOAD, 8'h33, 8'd0);
    push(OP_UP, 8'h00, 8'd2);
    push(OP_DOWN, 8'h00, 8'd3);
    push(OP_LOAD, 8'h44, 8'd0);
    chk("c_level_full", 32'(fifo_level), 32'h4);
    chk("c_ready_low",  32'(cmd_ready),  32'h0);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 8'h00; cmd_len = 8'd7;
    repeat (3) tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && fifo_level == 4; i++) tick();
    chk("c_level_pop",  32'(fifo_level), 32'h3);
    chk("c_ready_back", 32'(cmd_ready),  32'h1);
    chk("c_first_load", 32'(load),       32'h1);
    chk("c_first_data", 32'(data),       32'h33);
    for (int i = 0; i < 60 && (busy || fifo_level != 0); i++) tick();
    chk("c_drained", 32'(busy), 32'h0);
    chk("c_last",    32'(data), 32'h44);

    // Reserved op between LOAD 10 and UP 2
    push(OP_LOAD, 8'h10, 8'd0);
    push(OP_RSV, 8'hEE, 8'd9);
    push(OP_UP, 8'h00, 8'd2);
    chk("d_err",  32'(cmd_err), 32'h1);
    chk("d_load", 32'(load),    32'h0);
    chk("d_data", 32'(data),    32'h10);
    tick();
    chk("d_err_gone", 32'(cmd_err), 32'h0);
    chk("d_up",       32'(updown),  32'h1);
    chk("d_up_busy",  32'(busy),    32'h1);
    repeat (3) tick();

    // Counter underflow wrap: LOAD 01, DOWN 3
    ce[0] = 8'h01; ce[1] = 8'h00; ce[2] = 8'hFF; ce[3] = 8'hFE;
    push(OP_LOAD, 8'h01, 8'd0);
    push(OP_DOWN, 8'h00, 8'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("e_cnt", 32'(cnt), 32'(ce[i]));
    end

    // Reset mid-RUN with three commands queued
    push(OP_DOWN, 8'h00, 8'd20);
    push(OP_LOAD, 8'h55, 8'd0);
    push(OP_UP, 8'h00, 8'd3);
    push(OP_LOAD, 8'h66, 8'd0);
    tick();
    chk("f_pre_level", 32'(fifo_level), 32'h3);
    rst = 1'b1;
    #1;
    chk("f_load",   32'(load),       32'h0);
    chk("f_updown", 32'(updown),     32'h1);
    chk("f_data",   32'(data),       32'h0);
    chk("f_busy",   32'(busy),       32'h0);
    chk("f_level",  32'(fifo_level), 32'h0);
    chk("f_ready",  32'(cmd_ready),  32'h1);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    push(OP_LOAD, 8'h5A, 8'd0);
    tick();
    chk("f_after_load", 32'(load), 32'h1);
    chk("f_after_data", 32'(data), 32'h5A);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
- Command sequencer sitting directly upstream of the up/down counter; drives its load, updown and data inputs.
- Accepts commands over a valid/ready interface and buffers them in a small FIFO.
- Plays each command out cycle-accurately: a one-cycle load, or an up or down count phase of programmable length.
- Lets a bench or controller script counter activity without cycle-by-cycle driving.

Parameters:
- WIDTH, 8, width of cmd_data and data; must match the counter's data/data_out width.
- LEN_W, 8, width of cmd_len.
- DEPTH, 4, command FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_op  input  2  00=LOAD, 01=UP, 10=DOWN, 11=reserved.
- cmd_data  input  WIDTH  load value; ignored for UP/DOWN.
- cmd_len  input  LEN_W  count-phase cycles; ignored for LOAD.
- load  output  1  to counter load.
- updown  output  1  to counter updown (1=up).
- data  output  WIDTH  to counter data.
- busy  output  1  a command is executing.
- cmd_done  output  1  one-cycle pulse on the last cycle of each executed command.
- cmd_err  output  1  one-cycle pulse when a reserved op is popped.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_level=0, cmd_ready=1, load=0, updown=1, data=0, busy=0, cmd_done=0, cmd_err=0, FSM=IDLE.
- Reset mid-command aborts the command and flushes the FIFO; no cmd_done is issued.
- Push: a command is written when cmd_valid && cmd_ready at the rising edge. cmd_ready is low when full, so a full FIFO never accepts a push, even if a pop happens in the same cycle.
- fifo_level reflects push and pop of the same edge.
- Pop: FIFO read pointer wraps modulo DEPTH; pop happens only in the cycles listed below.
- All outputs are registered.
- FSM state IDLE:
  - If the FIFO is empty: stay in IDLE with load=0, busy=0; updown holds its last value, data holds.
  - If the FIFO is non-empty: pop and decode the head command.
- Decode of a popped command:
  - LOAD: next cycle load=1, data=cmd_data, busy=1, cmd_done=1; state LOADING.
  - UP/DOWN: next cycle updown=1/0, load=0, busy=1; rem=max(cmd_len,1); state RUN.
  - Reserved (11): dropped; cmd_err=1 next cycle; no load/updown change; stay IDLE, and the next entry may pop the following cycle.
- State LOADING lasts exactly one cycle. If the FIFO is non-empty in that cycle, pop and decode (back-to-back, no bubble); otherwise go to IDLE with load=0.
- State RUN:
  - Each cycle rem decrements.
  - The cycle with rem==1 is the last: cmd_done=1 during it.
  - In that last cycle, pop and decode if the FIFO is non-empty, else go to IDLE.
  - updown is constant for the whole phase: exactly max(cmd_len,1) cycles.
- cmd_len=0 is treated as 1.
- Latency: a command accepted at edge N (empty FIFO, IDLE) is popped at edge N+1; its outputs are visible from cycle N+2.
- Consecutive commands produce contiguous output phases with no idle cycle.
- data changes only on a LOAD decode; load is never high for more than one cycle per LOAD command.
- busy stays 1 across back-to-back commands.
- Simultaneous push and pop (FIFO not full): both take effect; fifo_level is unchanged.

Test Plan:
- Reset check: assert rst mid-RUN with 3 entries queued -> same cycle load=0, updown=1, data=0, busy=0, fifo_level=0, cmd_ready=1.
- LOAD 8'hA5 then UP len 5 -> load=1, data=A5 for 1 cycle, immediately followed by 5 cycles updown=1, load=0. Counter data_out goes A5,A6..AA; cmd_done pulses on the load cycle and on the 5th up cycle.
- DOWN len 0 -> exactly 1 cycle updown=0, cmd_done in that cycle, then IDLE with busy=0 and updown held at 0.
- Push 4 commands while RUN len 20 executes -> fifo_level=4, cmd_ready=0; a 5th valid is not accepted. ready returns the cycle after the next pop, and all 4 commands execute in order.
- Reserved op 11 between LOAD 8'h10 and UP len 2 -> one cmd_err pulse; no extra load; UP follows within one cycle of the err pulse.
- Underflow wrap: LOAD 8'h01, DOWN len 3 -> counter data_out 01,00,FF,FE; sequencer outputs unaffected by the wrap.
